// File: rtl/mem_pkg.sv
// Shared types for the MemCommon requester: controller response codes,
// client-facing status codes, initiator FSM states and a counter-width helper.
package mem_pkg;

    // Response code the memory controller drives back on mem_resp.
    typedef enum logic [1:0] {
        MR_IDLE = 2'b00,
        MR_WAIT = 2'b01,
        MR_OK   = 2'b10,
        MR_ERR  = 2'b11
    } resp_e;

    // Completion status returned to the client with each response.
    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_ERR     = 2'd1,
        ST_TIMEOUT = 2'd2
    } status_e;

    // Initiator FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Bits needed to count 0..n inclusive, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_initiator.sv
// Requester side of the MemCommon protocol. Takes one client command per
// cmd handshake, issues it to the controller with a single-cycle mem_valid
// strobe, re-issues on ERR up to MaxRetries times, aborts after
// TimeoutCycles WAIT cycles, and returns data/status on the rsp port.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid, once raised, holds its payload stable until that edge.
// Only one transaction is ever outstanding.
module mem_initiator
    import mem_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 64,
    parameter int MaxRetries    = 2
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [AddrWidth-1:0] cmd_addr,
    input  logic [DataWidth-1:0] cmd_wData,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_rData,
    output status_e              rsp_status,
    output logic                 mem_valid,
    output logic                 mem_write,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wData,
    input  resp_e                mem_resp,
    input  logic [DataWidth-1:0] mem_rData,
    output state_e               dbg_state
);

    localparam int TW = cnt_width(TimeoutCycles);
    localparam int RW = cnt_width(MaxRetries);

    // Saturation point of the timeout counter and the count at which the
    // current WAIT cycle is the last one allowed.
    localparam logic [TW-1:0] TO_MAX    = TW'(TimeoutCycles);
    localparam logic [TW-1:0] TO_LAST   = TW'(TimeoutCycles - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MaxRetries);

    state_e               state_q,     state_d;
    logic                 mem_write_q, mem_write_d;
    logic [AddrWidth-1:0] mem_addr_q,  mem_addr_d;
    logic [DataWidth-1:0] mem_wData_q, mem_wData_d;
    logic [DataWidth-1:0] rsp_rData_q, rsp_rData_d;
    status_e              rsp_status_q, rsp_status_d;
    logic [RW-1:0]        retry_q,     retry_d;
    logic [TW-1:0]        tmo_q,       tmo_d;

    // Next-state, request capture, retry/timeout bookkeeping and response latch.
    always_comb begin
        state_d      = state_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wData_d  = mem_wData_q;
        rsp_rData_d  = rsp_rData_q;
        rsp_status_d = rsp_status_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    mem_write_d = cmd_write;
                    mem_addr_d  = cmd_addr;
                    mem_wData_d = cmd_wData;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // Every (re-)issue gets a fresh timeout window.
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                unique case (mem_resp)
                    MR_OK: begin
                        rsp_rData_d  = mem_write_q ? '0 : mem_rData;
                        rsp_status_d = ST_OK;
                        state_d      = RESP;
                    end
                    MR_ERR: begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 1'b1;
                            state_d = ISSUE;
                        end else begin
                            rsp_rData_d  = '0;
                            rsp_status_d = ST_ERR;
                            state_d      = RESP;
                        end
                    end
                    default: begin
                        if (tmo_q != TO_MAX) begin
                            tmo_d = tmo_q + 1'b1;
                        end
                        if ((TimeoutCycles != 0) && (tmo_q == TO_LAST)) begin
                            rsp_rData_d  = '0;
                            rsp_status_d = ST_TIMEOUT;
                            state_d      = RESP;
                        end
                    end
                endcase
            end
            RESP: begin
                if (rsp_ready) begin
                    retry_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wData_q  <= '0;
            rsp_rData_q  <= '0;
            rsp_status_q <= ST_OK;
            retry_q      <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wData_q  <= mem_wData_d;
            rsp_rData_q  <= rsp_rData_d;
            rsp_status_q <= rsp_status_d;
            retry_q      <= retry_d;
            tmo_q        <= tmo_d;
        end
    end

    // cmd_ready is gated by reset so it stays low while nReset is asserted.
    assign cmd_ready  = nReset && (state_q == IDLE);
    assign mem_valid  = (state_q == ISSUE);
    assign rsp_valid  = (state_q == RESP);
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wData  = mem_wData_q;
    assign rsp_rData  = rsp_rData_q;
    assign rsp_status = rsp_status_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: reset, read, write, retry, timeout,
// response backpressure and reset in the middle of a transaction.
module tb_mem_initiator;
    import mem_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;
    localparam int MR = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          nReset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wData;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rData;
    status_e       rsp_status;
    logic          mem_valid, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wData;
    resp_e         mem_resp;
    logic [DW-1:0] mem_rData;
    state_e        dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Controller response script: one entry consumed per non-strobe cycle.
    resp_e         resp_q[$];
    logic [DW-1:0] rdata_q[$];

    mem_initiator #(
        .DataWidth(DW), .AddrWidth(AW), .TimeoutCycles(TO), .MaxRetries(MR)
    ) dut (
        .clk(clk), .nReset(nReset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wData(cmd_wData),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rData(rsp_rData), .rsp_status(rsp_status),
        .mem_valid(mem_valid), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wData(mem_wData),
        .mem_resp(mem_resp), .mem_rData(mem_rData),
        .dbg_state(dbg_state)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic push(input resp_e r, input logic [DW-1:0] d);
        resp_q.push_back(r);
        rdata_q.push_back(d);
    endtask

    // Presents a command and returns at the negedge of the strobe cycle.
    task automatic send_cmd(input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            cmd_valid = 1'b1;
            cmd_write = w;
            cmd_addr  = a;
            cmd_wData = d;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    // Plays the controller from the strobe cycle (cycle 1 after handshake)
    // until rsp_valid; reports strobe count, rsp_valid cycle and whether the
    // request pins stayed stable whenever the strobe was low.
    task automatic run_txn(output int pulses, output int lat,
                           output bit hold_ok, output bit done);
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        pulses  = 0;
        lat     = 0;
        hold_ok = 1'b1;
        done    = 1'b0;
        w = mem_write;
        a = mem_addr;
        d = mem_wData;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (rsp_valid) begin
                lat  = cyc;
                done = 1'b1;
                break;
            end
            if (mem_valid) begin
                pulses++;
                mem_resp  = MR_IDLE;
                mem_rData = '0;
            end else begin
                if (mem_addr !== a || mem_wData !== d || mem_write !== w)
                    hold_ok = 1'b0;
                if (resp_q.size() > 0) begin
                    mem_resp  = resp_q.pop_front();
                    mem_rData = rdata_q.pop_front();
                end else begin
                    mem_resp  = MR_WAIT;
                    mem_rData = '0;
                end
            end
            @(negedge clk);
        end
        mem_resp  = MR_IDLE;
        mem_rData = '0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready);
        end
        tests_run++;
        if ({mem_valid, mem_write, rsp_valid} !== 3'b000 ||
            mem_addr !== '0 || mem_wData !== '0 || rsp_rData !== '0 ||
            rsp_status !== ST_OK) begin
            tests_failed++;
            $display("FAIL reset_outputs: got mv=%b mw=%b rv=%b a=%h wd=%h rd=%h st=%0d want all 0",
                     mem_valid, mem_write, rsp_valid, mem_addr, mem_wData, rsp_rData, rsp_status);
        end
        @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_read();
        bit ok, hold_ok, done;
        int pulses, lat;
        // OK on the third WAIT cycle: rsp_valid 5 cycles after the handshake.
        push(MR_WAIT, 32'h0);
        push(MR_WAIT, 32'h0);
        push(MR_OK, 32'hDEADBEEF);
        send_cmd(1'b0, 32'h100, 32'h12345678, ok);
        tests_run++;
        if (!ok || mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_issue: got ok=%b mv=%b a=%h w=%b want 1 1 00000100 0",
                     ok, mem_valid, mem_addr, mem_write);
        end
        run_txn(pulses, lat, hold_ok, done);
        tests_run++;
        if (!done || pulses != 1 || lat != 5 || !hold_ok) begin
            tests_failed++;
            $display("FAIL read_timing: got done=%b pulses=%0d lat=%0d hold=%b want 1 1 5 1",
                     done, pulses, lat, hold_ok);
        end
        tests_run++;
        if (rsp_rData !== 32'hDEADBEEF || rsp_status !== ST_OK) begin
            tests_failed++;
            $display("FAIL read_data: got %h st=%0d want deadbeef st=0", rsp_rData, rsp_status);
        end
        take_rsp();
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_handshake: got rv=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_write();
        bit ok, hold_ok, done;
        int pulses, lat;
        push(MR_WAIT, 32'h0);
        push(MR_WAIT, 32'h0);
        push(MR_OK, 32'hFFFFFFFF);
        send_cmd(1'b1, 32'h4, 32'hA5A5A5A5, ok);
        tests_run++;
        if (!ok || mem_write !== 1'b1 || mem_addr !== 32'h4 || mem_wData !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL write_issue: got ok=%b w=%b a=%h wd=%h want 1 1 00000004 a5a5a5a5",
                     ok, mem_write, mem_addr, mem_wData);
        end
        run_txn(pulses, lat, hold_ok, done);
        tests_run++;
        if (!done || !hold_ok || lat != 5 || rsp_rData !== '0 || rsp_status !== ST_OK) begin
            tests_failed++;
            $display("FAIL write_rsp: got done=%b hold=%b lat=%0d rd=%h st=%0d want 1 1 5 0 0",
                     done, hold_ok, lat, rsp_rData, rsp_status);
        end
        take_rsp();
    endtask

    task automatic test_retry();
        bit ok, hold_ok, done;
        int pulses, lat;
        push(MR_ERR, 32'h0);
        push(MR_ERR, 32'h0);
        push(MR_OK, 32'h0BADF00D);
        send_cmd(1'b0, 32'h40, 32'h0, ok);
        run_txn(pulses, lat, hold_ok, done);
        tests_run++;
        if (!ok || !done || pulses != 3 || lat != 7 || rsp_status !== ST_OK ||
            rsp_rData !== 32'h0BADF00D) begin
            tests_failed++;
            $display("FAIL retry_ok: got pulses=%0d lat=%0d st=%0d rd=%h want 3 7 0 0badf00d",
                     pulses, lat, rsp_status, rsp_rData);
        end
        take_rsp();
        // Retry count must have been cleared by the previous handshake.
        push(MR_ERR, 32'h11111111);
        push(MR_ERR, 32'h22222222);
        push(MR_ERR, 32'h33333333);
        send_cmd(1'b0, 32'h44, 32'h0, ok);
        run_txn(pulses, lat, hold_ok, done);
        tests_run++;
        if (!ok || !done || pulses != 3 || lat != 7 || rsp_status !== ST_ERR ||
            rsp_rData !== '0) begin
            tests_failed++;
            $display("FAIL retry_err: got pulses=%0d lat=%0d st=%0d rd=%h want 3 7 1 0",
                     pulses, lat, rsp_status, rsp_rData);
        end
        take_rsp();
    endtask

    task automatic test_timeout();
        bit ok, hold_ok, done;
        int pulses, lat;
        // Stuck at WAIT: 8 WAIT cycles after the strobe, rsp_valid on the 9th.
        send_cmd(1'b0, 32'h80, 32'h0, ok);
        run_txn(pulses, lat, hold_ok, done);
        tests_run++;
        if (!ok || !done || pulses != 1 || lat != 10 || rsp_status !== ST_TIMEOUT ||
            rsp_rData !== '0) begin
            tests_failed++;
            $display("FAIL timeout: got pulses=%0d lat=%0d st=%0d rd=%h want 1 10 2 0",
                     pulses, lat, rsp_status, rsp_rData);
        end
        take_rsp();
        // OK on the 8th WAIT cycle wins over expiry.
        for (int i = 0; i < 7; i++) push(MR_WAIT, 32'h0);
        push(MR_OK, 32'hCAFE0001);
        send_cmd(1'b0, 32'h84, 32'h0, ok);
        run_txn(pulses, lat, hold_ok, done);
        tests_run++;
        if (!ok || !done || lat != 10 || rsp_status !== ST_OK || rsp_rData !== 32'hCAFE0001) begin
            tests_failed++;
            $display("FAIL timeout_ok_priority: got lat=%0d st=%0d rd=%h want 10 0 cafe0001",
                     lat, rsp_status, rsp_rData);
        end
        take_rsp();
        // A retry restarts the timeout window.
        for (int i = 0; i < 5; i++) push(MR_WAIT, 32'h0);
        push(MR_ERR, 32'h0);
        send_cmd(1'b0, 32'h88, 32'h0, ok);
        run_txn(pulses, lat, hold_ok, done);
        tests_run++;
        if (!ok || !done || pulses != 2 || lat != 17 || rsp_status !== ST_TIMEOUT) begin
            tests_failed++;
            $display("FAIL timeout_restart: got pulses=%0d lat=%0d st=%0d want 2 17 2",
                     pulses, lat, rsp_status);
        end
        take_rsp();
    endtask

    task automatic test_backpressure();
        bit ok, hold_ok, done;
        int pulses, lat;
        // Immediate OK gives the minimum latency: rsp_valid at N+3.
        push(MR_OK, 32'h11223344);
        send_cmd(1'b0, 32'hC0, 32'h0, ok);
        run_txn(pulses, lat, hold_ok, done);
        tests_run++;
        if (!ok || !done || lat != 3 || rsp_rData !== 32'h11223344) begin
            tests_failed++;
            $display("FAIL min_latency: got lat=%0d rd=%h want 3 11223344", lat, rsp_rData);
        end
        // Hold off the response and offer a command that must be ignored.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'hFFFF0000;
        cmd_wData = 32'h77777777;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_rData !== 32'h11223344 || rsp_status !== ST_OK ||
                cmd_ready !== 1'b0 || mem_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: got rv=%b rd=%h st=%0d rdy=%b mv=%b want 1 11223344 0 0 0",
                         i, rsp_valid, rsp_rData, rsp_status, cmd_ready, mem_valid);
            end
        end
        cmd_valid = 1'b0;
        take_rsp();
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || mem_valid !== 1'b0 || mem_addr !== 32'hC0) begin
            tests_failed++;
            $display("FAIL backpressure_ignored_cmd: got rdy=%b mv=%b a=%h want 1 0 000000c0",
                     cmd_ready, mem_valid, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, hold_ok, done;
        int pulses, lat;
        send_cmd(1'b1, 32'h200, 32'h99999999, ok);
        mem_resp = MR_WAIT;
        @(negedge clk);
        @(negedge clk);
        #2;
        nReset = 1'b0;
        #1;
        tests_run++;
        if (!ok || {mem_valid, mem_write, rsp_valid, cmd_ready} !== 4'b0000 ||
            mem_addr !== '0 || mem_wData !== '0 || rsp_rData !== '0 || rsp_status !== ST_OK) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got mv=%b mw=%b rv=%b rdy=%b a=%h wd=%h want all 0",
                     mem_valid, mem_write, rsp_valid, cmd_ready, mem_addr, mem_wData);
        end
        @(negedge clk);
        nReset   = 1'b1;
        mem_resp = MR_IDLE;
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_recover: got rdy=%b rv=%b want 1 0", cmd_ready, rsp_valid);
        end
        resp_q.delete();
        rdata_q.delete();
        push(MR_WAIT, 32'h0);
        push(MR_OK, 32'h5A5A0000);
        send_cmd(1'b0, 32'h300, 32'h0, ok);
        run_txn(pulses, lat, hold_ok, done);
        tests_run++;
        if (!ok || !done || pulses != 1 || lat != 4 || rsp_rData !== 32'h5A5A0000 ||
            rsp_status !== ST_OK) begin
            tests_failed++;
            $display("FAIL reset_mid_next_cmd: got pulses=%0d lat=%0d rd=%h st=%0d want 1 4 5a5a0000 0",
                     pulses, lat, rsp_rData, rsp_status);
        end
        take_rsp();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        nReset    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wData = '0;
        rsp_ready = 1'b0;
        mem_resp  = MR_IDLE;
        mem_rData = '0;

        test_reset();
        test_read();
        test_write();
        test_retry();
        test_timeout();
        test_backpressure();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
